mem_access_ctrl: RTL and testbench

Parametrised multicycle memory access controller. It replaces the fixed two-way PC/ALU-address select in front of the single unified memory with an N-channel round-robin arbiter, a request/grant/valid handshake, byte-enabled writes, configurable wait states and address error detection. It sits between the processor datapath (instruction fetch, data access and future requesters) and a word-organised internal RAM array.

---
 rtl/mem_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Multicycle memory access controller: N-channel round-robin arbiter in front of a
// word-organised RAM with byte-enabled writes, configurable wait states and address checks.
module mem_access_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WAIT   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          we,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] be,
    output logic [NUM_CH-1:0]          gnt,
    output logic [NUM_CH-1:0]          rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic                       busy
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BE_W);
    localparam int unsigned MEM_AW = $clog2(DEPTH);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          wait_q;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     cur_ch;

    logic                sel_valid;
    logic [CH_W-1:0]     sel_ch;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;
    logic [ADDR_W-1:0]   sel_idx_full;
    logic                sel_bad;

    logic                l_we;
    logic                l_bad;
    logic [MEM_AW-1:0]   l_idx;
    logic [DATA_W-1:0]   l_wdata;
    logic [BE_W-1:0]     l_be;

    logic                accept;
    logic                last;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   result;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Round-robin pick: first requester strictly after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        sel_valid = 1'b0;
        sel_ch    = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_CH;
            if (!sel_valid && req[CH_W'(cand)]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_W'(cand);
            end
        end
    end

    // Payload of the selected channel plus its address checks.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel_ch == CH_W'(k)) begin
                sel_addr  = addr[k*ADDR_W +: ADDR_W];
                sel_we    = we[k];
                sel_wdata = wdata[k*DATA_W +: DATA_W];
                sel_be    = be[k*BE_W +: BE_W];
            end
        end
        sel_idx_full = sel_addr >> OFF_W;
        sel_bad      = (|(sel_addr & ADDR_W'(BE_W - 1))) || (sel_idx_full >= ADDR_W'(DEPTH));
    end

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && sel_valid;
    assign last   = (state_q == ACCESS) && (wait_q == 3'(WAIT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (last) state_d = DONE;
            DONE:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte merge against the currently stored word.
    always_comb begin
        old_word = mem[l_idx];
        merged   = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (l_be[b]) merged[b*8 +: 8] = l_wdata[b*8 +: 8];
        end
        if (l_bad)     result = '0;
        else if (l_we) result = merged;
        else           result = old_word;
    end

    // Array is intentionally not reset; a write only lands at the end of a live ACCESS.
    always_ff @(posedge clk) begin
        if (last && l_we && !l_bad) mem[l_idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= '0;
            rr_ptr  <= CH_W'(NUM_CH - 1);
            cur_ch  <= '0;
            l_we    <= 1'b0;
            l_bad   <= 1'b0;
            l_idx   <= '0;
            l_wdata <= '0;
            l_be    <= '0;
            gnt     <= '0;
            rvalid  <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                wait_q  <= '0;
                rr_ptr  <= sel_ch;
                cur_ch  <= sel_ch;
                l_we    <= sel_we;
                l_bad   <= sel_bad;
                l_idx   <= sel_idx_full[MEM_AW-1:0];
                l_wdata <= sel_wdata;
                l_be    <= sel_be;
            end else if ((state_q == ACCESS) && !last) begin
                wait_q <= wait_q + 3'd1;
            end
            gnt    <= accept ? (NUM_CH'(1) << sel_ch) : '0;
            rvalid <= last ? (NUM_CH'(1) << cur_ch) : '0;
            if (last) begin
                rdata <= result;
                err   <= l_bad;
            end
            busy <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT=0 and WAIT=3) checked every cycle against
// a transaction-timeline model, plus directed transfers with literal expectations.
module tb_mem_access_ctrl;

    localparam int unsigned W1 = 3;

    logic        clk;
    logic        rst_n  [2];
    logic [1:0]  req    [2];
    logic [1:0]  we     [2];
    logic [63:0] addr   [2];
    logic [63:0] wdata  [2];
    logic [7:0]  be     [2];
    logic [1:0]  gnt    [2];
    logic [1:0]  rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];
    logic        busy   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ctrl #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(256), .NUM_CH(2),
            .WAIT((g == 0) ? 0 : W1)
        ) dut (
            .clk(clk), .rst_n(rst_n[g]), .req(req[g]), .we(we[g]), .addr(addr[g]),
            .wdata(wdata[g]), .be(be[g]), .gnt(gnt[g]), .rvalid(rvalid[g]),
            .rdata(rdata[g]), .err(err[g]), .busy(busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // Model: a transfer accepted at edge A shows gnt after A, completes after A+1+W,
    // and the next acceptance is possible at edge A+2+W.
    int          n;
    int          acc_at [2];
    int          cur_ch [2];
    int          rr     [2];
    bit          p_we   [2];
    bit          p_bad  [2];
    int          p_idx  [2];
    logic [31:0] p_wd   [2];
    logic [3:0]  p_be   [2];
    logic [31:0] mem_m  [2][256];
    bit          known  [2][256];
    logic [1:0]  e_gnt  [2];
    logic [1:0]  e_rv   [2];
    bit          e_busy [2];
    bit          e_err  [2];
    bit          e_known[2];
    logic [31:0] e_rd   [2];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int waitof(int g);
        return (g == 0) ? 0 : int'(W1);
    endfunction

    function automatic void model_edge(int g);
        int w;
        logic [31:0] a;
        logic [31:0] nw;
        int c;
        w = waitof(g);
        e_gnt[g] = 2'b00;
        e_rv[g]  = 2'b00;
        if (!rst_n[g]) begin
            acc_at[g] = -100;
            rr[g]     = 1;
            e_busy[g] = 1'b0;
            return;
        end
        if (n == acc_at[g] + 1 + w) begin
            e_rv[g] = 2'b01 << cur_ch[g];
            if (p_bad[g]) begin
                e_rd[g] = 32'h0; e_err[g] = 1'b1; e_known[g] = 1'b1;
            end else begin
                e_err[g] = 1'b0;
                nw = mem_m[g][p_idx[g]];
                if (p_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[g][b]) nw[b*8 +: 8] = p_wd[g][b*8 +: 8];
                    known[g][p_idx[g]] = known[g][p_idx[g]] || (p_be[g] == 4'hF);
                    mem_m[g][p_idx[g]] = nw;
                end
                e_rd[g]    = nw;
                e_known[g] = known[g][p_idx[g]];
            end
        end
        if (n >= acc_at[g] + 2 + w && req[g] != 2'b00) begin
            c = 0;
            for (int k = 1; k <= 2; k++) begin
                if (req[g][(rr[g] + k) % 2]) begin
                    c = (rr[g] + k) % 2;
                    break;
                end
            end
            a          = addr[g][c*32 +: 32];
            p_bad[g]   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
            p_idx[g]   = int'((a >> 2) & 32'hFF);
            p_we[g]    = we[g][c];
            p_wd[g]    = wdata[g][c*32 +: 32];
            p_be[g]    = be[g][c*4 +: 4];
            cur_ch[g]  = c;
            rr[g]      = c;
            acc_at[g]  = n;
            e_gnt[g]   = 2'b01 << c;
        end
        e_busy[g] = (n >= acc_at[g]) && (n <= acc_at[g] + 1 + w);
    endfunction

    function automatic void compare(int g);
        if (!rst_n[g]) begin
            chk($sformatf("i%0d_rst_gnt", g), 32'(gnt[g]), 32'h0);
            chk($sformatf("i%0d_rst_rvalid", g), 32'(rvalid[g]), 32'h0);
            chk($sformatf("i%0d_rst_rdata", g), rdata[g], 32'h0);
            chk($sformatf("i%0d_rst_busy", g), 32'(busy[g]), 32'h0);
        end else begin
            chk($sformatf("i%0d_gnt", g), 32'(gnt[g]), 32'(e_gnt[g]));
            chk($sformatf("i%0d_rvalid", g), 32'(rvalid[g]), 32'(e_rv[g]));
            chk($sformatf("i%0d_busy", g), 32'(busy[g]), 32'(e_busy[g]));
            if (e_rv[g] != 2'b00) begin
                chk($sformatf("i%0d_err", g), 32'(err[g]), 32'(e_err[g]));
                if (e_known[g]) chk($sformatf("i%0d_rdata", g), rdata[g], e_rd[g]);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        n++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic xfer(input int g, input int c, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int gat, output int bsy);
        bit got;
        got = 1'b0; rd = '0; er = 1'b0; lat = 0; gat = 0; bsy = 0;
        req[g][c] = 1'b1;
        we[g][c]  = w;
        addr[g][c*32 +: 32]  = a;
        wdata[g][c*32 +: 32] = d;
        be[g][c*4 +: 4]      = b;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            lat++;
            if (busy[g]) bsy++;
            if (gnt[g][c]) begin
                req[g][c] = 1'b0;
                gat = lat;
            end
            if (rvalid[g][c]) begin
                got = 1'b1;
                rd  = rdata[g];
                er  = err[g];
            end
        end
        chk($sformatf("i%0d_xfer_done", g), 32'(got), 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, gat, bsy;
    int          gq_ch [$];
    int          gq_at [$];

    initial begin
        checks = 0; errors = 0; n = 0;
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0;
            req[g] = '0; we[g] = '0; addr[g] = '0; wdata[g] = '0; be[g] = '0;
            acc_at[g] = -100; rr[g] = 1; cur_ch[g] = 0;
            for (int i = 0; i < 256; i++) begin
                known[g][i] = 1'b0;
                mem_m[g][i] = '0;
            end
        end
        step();
        step();
        chk("reset_busy", 32'(busy[0]), 32'h0);
        chk("reset_rdata", rdata[0], 32'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        // Single read after preload
        xfer(0, 0, 1'b1, 32'd128, 32'hDEADBEEF, 4'hF, rd, er, lat, gat, bsy);
        chk("preload_wr_rdata", rd, 32'hDEADBEEF);
        xfer(0, 0, 1'b0, 32'd128, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("read_rdata", rd, 32'hDEADBEEF);
        chk("read_err", 32'(er), 32'h0);
        chk("read_gnt_lat", 32'(gat), 32'd1);
        chk("read_rv_lat", 32'(lat), 32'd2);

        // Byte-enable merge
        xfer(0, 1, 1'b1, 32'd20, 32'h11223344, 4'hF, rd, er, lat, gat, bsy);
        xfer(0, 1, 1'b1, 32'd20, 32'hAABBCCDD, 4'b0101, rd, er, lat, gat, bsy);
        chk("be_wr_rdata", rd, 32'h11BB33DD);
        xfer(0, 0, 1'b0, 32'd20, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("be_rd_rdata", rd, 32'h11BB33DD);
        xfer(0, 1, 1'b1, 32'd20, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("be_zero_rdata", rd, 32'h11BB33DD);

        // Address errors leave the array alone
        xfer(0, 0, 1'b1, 32'd0, 32'hCAFEF00D, 4'hF, rd, er, lat, gat, bsy);
        xfer(0, 1, 1'b0, 32'd1026, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("misal_err", 32'(er), 32'h1);
        chk("misal_rdata", rd, 32'h0);
        xfer(0, 1, 1'b1, 32'd1024, 32'h12345678, 4'hF, rd, er, lat, gat, bsy);
        chk("oob_err", 32'(er), 32'h1);
        chk("oob_rdata", rd, 32'h0);
        xfer(0, 1, 1'b0, 32'd0, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("oob_keep_word0", rd, 32'hCAFEF00D);
        chk("oob_keep_err", 32'(er), 32'h0);

        // Round robin with both channels held; last grant went to channel 1
        req[0] = 2'b11; we[0] = 2'b00;
        addr[0] = {32'd20, 32'd128};
        for (int i = 1; i <= 8; i++) begin
            step();
            if (gnt[0] != 2'b00) begin
                gq_ch.push_back(gnt[0][1] ? 1 : 0);
                gq_at.push_back(i);
            end
        end
        req[0] = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("rr_count", 32'(gq_ch.size()), 32'd4);
        if (gq_ch.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_order%0d", i), 32'(gq_ch[i]), 32'(i % 2));
                chk($sformatf("rr_when%0d", i), 32'(gq_at[i]), 32'(2 * i + 1));
            end
        end

        // Wait states on the WAIT=3 instance
        xfer(1, 0, 1'b1, 32'd8, 32'h0BADC0DE, 4'hF, rd, er, lat, gat, bsy);
        xfer(1, 0, 1'b0, 32'd8, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("wait_rdata", rd, 32'h0BADC0DE);
        chk("wait_rv_lat", 32'(lat), 32'd5);
        chk("wait_busy_cycles", 32'(bsy), 32'd5);

        // Reset in the second ACCESS cycle of a write
        req[1][0] = 1'b1; we[1][0] = 1'b1;
        addr[1][31:0] = 32'd8; wdata[1][31:0] = 32'hFFFFFFFF; be[1][3:0] = 4'hF;
        step();
        chk("abort_gnt", 32'(gnt[1]), 32'h1);
        req[1][0] = 1'b0;
        step();
        chk("abort_busy_before", 32'(busy[1]), 32'h1);
        rst_n[1] = 1'b0;
        #1;
        chk("abort_gnt0", 32'(gnt[1]), 32'h0);
        chk("abort_rvalid0", 32'(rvalid[1]), 32'h0);
        chk("abort_rdata0", rdata[1], 32'h0);
        chk("abort_err0", 32'(err[1]), 32'h0);
        chk("abort_busy0", 32'(busy[1]), 32'h0);
        step();
        step();
        rst_n[1] = 1'b1;
        for (int i = 0; i < 6; i++) step();
        xfer(1, 0, 1'b0, 32'd8, 32'h0, 4'h0, rd, er, lat, gat, bsy);
        chk("abort_keep_mem", rd, 32'h0BADC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
